// File: rtl/muldiv_pkg.sv
// Shared widths, the writeback entry layout and the round-robin grant type
// used by the mul/div writeback arbiter.
package muldiv_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned PHYS_W = 7;
  localparam int unsigned ROB_W  = 8;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [PHYS_W-1:0] dest_phys;
    logic [ROB_W-1:0]  rob_idx;
  } wb_entry_t;

  typedef enum logic {
    GRANT_MUL = 1'b0,
    GRANT_DIV = 1'b1
  } grant_e;

  // Source that wins a tie: the one opposite the previous grant.
  function automatic grant_e rr_pick(input grant_e last);
    return (last == GRANT_MUL) ? GRANT_DIV : GRANT_MUL;
  endfunction

endpackage

// File: rtl/muldiv_wb_fifo.sv
// Synchronous FIFO of writeback entries; push on full is accepted only when a
// pop happens in the same cycle, otherwise it is dropped and flagged.
module muldiv_wb_fifo
  import muldiv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  wb_entry_t     wdata_i,
  input  logic          pop_i,
  output wb_entry_t     rdata_o,
  output logic [CW-1:0] count_next_o,
  output logic          empty_o,
  output logic          drop_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o && !flush_i;
    do_push  = push_i && !flush_i && (!full || do_pop);
    drop_o   = push_i && !flush_i && full && !do_pop;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count_next_o = count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/muldiv_wb_arbiter.sv
// Merges mul/div result streams onto one ready/valid writeback port via
// per-source FIFOs and a round-robin output register. MULDIV_WB_STATS_EN adds counters.
module muldiv_wb_arbiter
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_FIFO_DEPTH = 4,
  parameter int unsigned DIV_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              mul_valid_i,
  input  logic [XLEN-1:0]   mul_result_i,
  input  logic [PHYS_W-1:0] mul_dest_phys_i,
  input  logic [ROB_W-1:0]  mul_rob_idx_i,
  input  logic              div_valid_i,
  input  logic [XLEN-1:0]   div_result_i,
  input  logic [PHYS_W-1:0] div_dest_phys_i,
  input  logic [ROB_W-1:0]  div_rob_idx_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_result_o,
  output logic [PHYS_W-1:0] wb_dest_phys_o,
  output logic [ROB_W-1:0]  wb_rob_idx_o,
  output logic              mul_stall_o,
  output logic              div_stall_o,
  output logic              overflow_o
`ifdef MULDIV_WB_STATS_EN
  ,
  output logic [31:0]       stat_wb_count_o,
  output logic [31:0]       stat_bp_cycles_o,
  output logic [31:0]       stat_drop_count_o
`endif
);

  localparam int unsigned MCW = $clog2(MUL_FIFO_DEPTH) + 1;
  localparam int unsigned DCW = $clog2(DIV_FIFO_DEPTH) + 1;

  wb_entry_t mul_in, div_in, mul_head, div_head, mul_cand, div_cand;
  wb_entry_t or_q, or_d;
  logic      wb_valid_q, wb_valid_d;
  grant_e    last_grant_q, last_grant_d;
  logic      mul_stall_q, div_stall_q, overflow_q;
  logic      mul_empty, div_empty, mul_drop, div_drop;
  logic      mul_push, mul_pop, div_push, div_pop;
  logic      mul_cand_v, div_cand_v, or_load, sel_mul, sel_div;
  logic [MCW-1:0] mul_count_next;
  logic [DCW-1:0] div_count_next;

  assign mul_in = '{result: mul_result_i, dest_phys: mul_dest_phys_i, rob_idx: mul_rob_idx_i};
  assign div_in = '{result: div_result_i, dest_phys: div_dest_phys_i, rob_idx: div_rob_idx_i};

  // An empty FIFO lets the same-cycle input fall straight through to the OR.
  assign mul_cand_v = !mul_empty || mul_valid_i;
  assign div_cand_v = !div_empty || div_valid_i;
  assign mul_cand   = mul_empty ? mul_in : mul_head;
  assign div_cand   = div_empty ? div_in : div_head;
  assign or_load    = !wb_valid_q || wb_ready_i;

  always_comb begin
    wb_valid_d   = wb_valid_q;
    or_d         = or_q;
    last_grant_d = last_grant_q;
    sel_mul      = 1'b0;
    sel_div      = 1'b0;
    if (flush_i) begin
      wb_valid_d = 1'b0;
    end else if (or_load) begin
      if (mul_cand_v && div_cand_v) begin
        if (rr_pick(last_grant_q) == GRANT_MUL) sel_mul = 1'b1;
        else                                    sel_div = 1'b1;
      end else if (mul_cand_v) begin
        sel_mul = 1'b1;
      end else if (div_cand_v) begin
        sel_div = 1'b1;
      end
      wb_valid_d = sel_mul || sel_div;
      if (sel_mul) begin
        or_d         = mul_cand;
        last_grant_d = GRANT_MUL;
      end else if (sel_div) begin
        or_d         = div_cand;
        last_grant_d = GRANT_DIV;
      end
    end
    mul_pop  = sel_mul && !mul_empty;
    div_pop  = sel_div && !div_empty;
    mul_push = mul_valid_i && !flush_i && !(sel_mul && mul_empty);
    div_push = div_valid_i && !flush_i && !(sel_div && div_empty);
  end

  muldiv_wb_fifo #(.DEPTH(MUL_FIFO_DEPTH)) u_mul_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_i       (mul_push),
    .wdata_i      (mul_in),
    .pop_i        (mul_pop),
    .rdata_o      (mul_head),
    .count_next_o (mul_count_next),
    .empty_o      (mul_empty),
    .drop_o       (mul_drop)
  );

  muldiv_wb_fifo #(.DEPTH(DIV_FIFO_DEPTH)) u_div_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_i       (div_push),
    .wdata_i      (div_in),
    .pop_i        (div_pop),
    .rdata_o      (div_head),
    .count_next_o (div_count_next),
    .empty_o      (div_empty),
    .drop_o       (div_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      or_q         <= '0;
      last_grant_q <= GRANT_MUL;
      mul_stall_q  <= 1'b0;
      div_stall_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      or_q         <= or_d;
      last_grant_q <= last_grant_d;
      mul_stall_q  <= (mul_count_next >= MCW'(MUL_FIFO_DEPTH - 1));
      div_stall_q  <= (div_count_next >= DCW'(DIV_FIFO_DEPTH - 1));
      overflow_q   <= overflow_q | mul_drop | div_drop;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_result_o    = or_q.result;
  assign wb_dest_phys_o = or_q.dest_phys;
  assign wb_rob_idx_o   = or_q.rob_idx;
  assign mul_stall_o    = mul_stall_q;
  assign div_stall_o    = div_stall_q;
  assign overflow_o     = overflow_q;

`ifdef MULDIV_WB_STATS_EN
  logic [31:0] wb_cnt_q, bp_cnt_q, drop_cnt_q;
  logic [32:0] drop_sum;

  // Both FIFOs may drop in the same cycle, so the drop counter can step by 2.
  assign drop_sum = {1'b0, drop_cnt_q} + 33'(mul_drop) + 33'(div_drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt_q   <= '0;
      bp_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wb_valid_q && wb_ready_i && (wb_cnt_q != '1))  wb_cnt_q <= wb_cnt_q + 1'b1;
      if (wb_valid_q && !wb_ready_i && (bp_cnt_q != '1)) bp_cnt_q <= bp_cnt_q + 1'b1;
      drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  assign stat_wb_count_o   = wb_cnt_q;
  assign stat_bp_cycles_o  = bp_cnt_q;
  assign stat_drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Table-driven bench for muldiv_wb_arbiter plus flush, reset and stats sequences.
module tb_muldiv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        mul_valid_i = 1'b0;
  logic [63:0] mul_result_i = '0;
  logic [6:0]  mul_dest_phys_i = '0;
  logic [7:0]  mul_rob_idx_i = '0;
  logic        div_valid_i = 1'b0;
  logic [63:0] div_result_i = '0;
  logic [6:0]  div_dest_phys_i = '0;
  logic [7:0]  div_rob_idx_i = '0;
  logic        wb_ready_i = 1'b0;
  logic        wb_valid_o;
  logic [63:0] wb_result_o;
  logic [6:0]  wb_dest_phys_o;
  logic [7:0]  wb_rob_idx_o;
  logic        mul_stall_o, div_stall_o, overflow_o;
`ifdef MULDIV_WB_STATS_EN
  logic [31:0] stat_wb_count_o, stat_bp_cycles_o, stat_drop_count_o;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  muldiv_wb_arbiter #(.MUL_FIFO_DEPTH(4), .DIV_FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .mul_valid_i     (mul_valid_i),
    .mul_result_i    (mul_result_i),
    .mul_dest_phys_i (mul_dest_phys_i),
    .mul_rob_idx_i   (mul_rob_idx_i),
    .div_valid_i     (div_valid_i),
    .div_result_i    (div_result_i),
    .div_dest_phys_i (div_dest_phys_i),
    .div_rob_idx_i   (div_rob_idx_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_result_o     (wb_result_o),
    .wb_dest_phys_o  (wb_dest_phys_o),
    .wb_rob_idx_o    (wb_rob_idx_o),
    .mul_stall_o     (mul_stall_o),
    .div_stall_o     (div_stall_o),
    .overflow_o      (overflow_o)
`ifdef MULDIV_WB_STATS_EN
    ,
    .stat_wb_count_o   (stat_wb_count_o),
    .stat_bp_cycles_o  (stat_bp_cycles_o),
    .stat_drop_count_o (stat_drop_count_o)
`endif
  );

  typedef struct {
    logic        mv;  logic [63:0] mr; logic [6:0] md; logic [7:0] mrob;
    logic        dv;  logic [63:0] dr; logic [6:0] dd; logic [7:0] drob;
    logic        rdy;
    logic        ev;  logic [63:0] er; logic [6:0] ed; logic [7:0] erob;
    logic [2:0]  eflags;  // {mul_stall, div_stall, overflow}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic mv, logic [63:0] mr, logic [6:0] md, logic [7:0] mrob,
                              logic dv, logic [63:0] dr, logic [6:0] dd, logic [7:0] drob,
                              logic rdy, logic ev, logic [63:0] er, logic [6:0] ed,
                              logic [7:0] erob, logic [2:0] eflags);
    vec_t v;
    v.mv = mv; v.mr = mr; v.md = md; v.mrob = mrob;
    v.dv = dv; v.dr = dr; v.dd = dd; v.drob = drob;
    v.rdy = rdy; v.ev = ev; v.er = er; v.ed = ed; v.erob = erob; v.eflags = eflags;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [63:0] mr, input logic [6:0] md,
                       input logic [7:0] mrob, input logic dv, input logic [63:0] dr,
                       input logic [6:0] dd, input logic [7:0] drob, input logic rdy,
                       input logic fl);
    mul_valid_i = mv; mul_result_i = mr; mul_dest_phys_i = md; mul_rob_idx_i = mrob;
    div_valid_i = dv; div_result_i = dr; div_dest_phys_i = dd; div_rob_idx_i = drob;
    wb_ready_i = rdy; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  function automatic logic [95:0] outs_all();
    return {17'd0, wb_valid_o, wb_result_o, wb_dest_phys_o, wb_rob_idx_o, mul_stall_o,
            div_stall_o, overflow_o};
  endfunction

  initial begin
    // Rows: inputs driven for one cycle, expected outputs after that edge.
    tbl.push_back(mk(1,64'h1234,5,9,   0,0,0,0,   1, 1,64'h1234,5,9, 3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 0,0,0,0,        3'b000));
    tbl.push_back(mk(1,64'hAA,3,1,     1,64'hBB,4,2, 1, 1,64'hBB,4,2, 3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'hAA,3,1,   3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 0,0,0,0,        3'b000));
    tbl.push_back(mk(0,0,0,0,          1,64'hA0,6,10, 0, 1,64'hA0,6,10, 3'b000));
    tbl.push_back(mk(0,0,0,0,          1,64'hA1,6,11, 0, 1,64'hA0,6,10, 3'b010));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'hA1,6,11,  3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 0,0,0,0,        3'b000));
    tbl.push_back(mk(1,64'h20,1,20,    1,64'h21,2,21, 1, 1,64'h20,1,20, 3'b010));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'h21,2,21,  3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 0,0,0,0,        3'b000));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1,64'h100+64'(k),7,8'(k), 0,0,0,0, 0, 1,64'h100,7,0,
                       (k >= 5) ? 3'b101 : (k >= 3) ? 3'b100 : 3'b000));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'h101,7,1,  3'b101));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'h102,7,2,  3'b001));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'h103,7,3,  3'b001));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 1,64'h104,7,4,  3'b001));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,   1, 0,0,0,0,        3'b001));

    #1;
    check("reset outputs", outs_all(), 96'd0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].mrob, tbl[i].dv, tbl[i].dr, tbl[i].dd,
            tbl[i].drob, tbl[i].rdy, 1'b0);
      step();
      if (tbl[i].ev)
        check($sformatf("row%0d payload", i),
              {17'd0, wb_valid_o, wb_result_o, wb_dest_phys_o, wb_rob_idx_o},
              {17'd0, 1'b1, tbl[i].er, tbl[i].ed, tbl[i].erob});
      else
        check($sformatf("row%0d valid", i), {95'd0, wb_valid_o}, 96'd0);
      check($sformatf("row%0d flags", i), {93'd0, mul_stall_o, div_stall_o, overflow_o},
            {93'd0, tbl[i].eflags});
    end

    // Flush while draining: buffered and flush-cycle inputs are all discarded.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h300 + 64'(k), 7'd8, 8'(30 + k), 1'b0, '0, '0, '0, 1'b0, 1'b0);
      step();
    end
    check("flush pre rob", {88'd0, wb_rob_idx_o}, 96'd30);
    drive(1'b1, 64'h333, 7'd8, 8'd33, 1'b1, 64'h400, 7'd9, 8'd40, 1'b1, 1'b1);
    step();
    check("flush state", {93'd0, wb_valid_o, mul_stall_o, div_stall_o}, 96'd0);
    check("flush keeps ovf", {95'd0, overflow_o}, 96'd1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      step();
      check($sformatf("post flush %0d", k), {95'd0, wb_valid_o}, 96'd0);
    end

    // Asynchronous reset with results in flight.
    drive(1'b1, 64'h500, 7'd3, 8'd50, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h510, 7'd3, 8'd51, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    check("pre rst valid", {95'd0, wb_valid_o}, 96'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 64'h600, 7'd4, 8'd60, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("async rst outputs", outs_all(), 96'd0);
    step();
    idle(1'b1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post rst %0d", k), {94'd0, wb_valid_o, overflow_o}, 96'd0);
    end

`ifdef MULDIV_WB_STATS_EN
    check("stats after rst", {stat_wb_count_o, stat_bp_cycles_o, stat_drop_count_o}, 96'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 64'h700 + 64'(k), 7'd2, 8'(70 + k), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      step();
    end
    drive(1'b1, 64'h800, 7'd1, 8'd80, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    step();
    step();
    check("stats counters", {stat_wb_count_o, stat_bp_cycles_o, stat_drop_count_o},
          {32'd4, 32'd3, 32'd1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
